// File: rtl/spi_boot_loader_pkg.sv
// Shared types and constants for the SPI-flash boot loader.
package spi_boot_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_HDR,
        ST_DATA,
        ST_AHB_ADDR,
        ST_AHB_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam int CMD_BYTES  = 4;
    localparam int HDR_BYTES  = 8;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 2;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte engine: clock divider, chip select and one byte per start pulse.
module spi_shift_engine
    import spi_boot_loader_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       ss_release,
    input  logic       miso,
    output logic       spi_clk,
    output logic       mosi,
    output logic       ss,
    output logic       busy,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] tx_sr;
    logic [7:0] rx_sr;

    assign rx_byte = rx_sr;

    // Between bytes spi_clk idles low, so the caller pauses the bus simply by not starting.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss         <= 1'b1;
            spi_clk    <= 1'b0;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            byte_valid <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
        end else begin
            byte_valid <= 1'b0;
            if (ss_release) begin
                ss <= 1'b1;
            end
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    ss      <= 1'b0;
                    mosi    <= tx_byte[7];
                    tx_sr   <= tx_byte[6:0];
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (!spi_clk) begin
                    spi_clk <= 1'b1;
                    rx_sr   <= {rx_sr[6:0], miso};
                end else begin
                    spi_clk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        busy       <= 1'b0;
                        byte_valid <= 1'b1;
                        mosi       <= 1'b0;
                    end else begin
                        mosi    <= tx_sr[6];
                        tx_sr   <= {tx_sr[5:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_boot_loader_v2.sv
// Boot loader: reads a header/payload/checksum image from SPI flash and writes it over AHB-Lite.
module spi_boot_loader_v2
    import spi_boot_loader_pkg::*;
#(
    parameter int          CLK_DIV      = 10,
    parameter logic [7:0]  FLASH_CMD    = 8'h03,
    parameter logic [23:0] FLASH_OFFSET = 24'h000000,
    parameter logic [15:0] MAGIC        = 16'hB007,
    parameter logic [3:0]  HPROT_VAL    = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miso,
    output logic        spi_clk,
    output logic        mosi,
    output logic        ss,
    output logic        spien,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err,
    output logic [31:0] spi_haddr,
    output logic        spi_hwrite,
    output logic [2:0]  spi_hsize,
    output logic [2:0]  spi_hburst,
    output logic        spi_hmastlock,
    output logic [3:0]  spi_hprot,
    output logic [1:0]  spi_htrans,
    output logic [31:0] spi_hwdata,
    input  logic        spi_hready,
    input  logic        spi_hresp,
    input  logic [31:0] spi_hrdata
);

    state_t      state, state_next;
    logic [2:0]  byte_cnt;
    logic [31:0] shift_reg, base_addr, haddr_r, hwdata_r, rx_word;
    logic [15:0] magic_r, len_r, sum;
    logic [14:0] word_cnt, len_words;
    logic [7:0]  tx_byte, rx_byte;
    logic        eng_start, eng_busy, byte_valid, eng_ss, shifting, terminal;
    logic        unused_hrdata;

    assign unused_hrdata = ^spi_hrdata;

    assign shifting  = state inside {ST_CMD, ST_HDR, ST_DATA, ST_CSUM};
    assign terminal  = state inside {ST_DONE, ST_ERR};
    assign eng_start = shifting && !eng_busy && !byte_valid;
    assign rx_word   = {shift_reg[23:0], rx_byte};
    // Byte length rounded up to whole words; pad bytes are still read and summed.
    assign len_words = 15'((17'(len_r) + 17'd3) >> 2);

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk        (clk),
        .reset      (reset),
        .start      (eng_start),
        .tx_byte    (tx_byte),
        .ss_release (terminal),
        .miso       (miso),
        .spi_clk    (spi_clk),
        .mosi       (mosi),
        .ss         (eng_ss),
        .busy       (eng_busy),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        tx_byte = 8'h00;
        if (state == ST_CMD) begin
            case (byte_cnt[1:0])
                2'd0:    tx_byte = FLASH_CMD;
                2'd1:    tx_byte = FLASH_OFFSET[23:16];
                2'd2:    tx_byte = FLASH_OFFSET[15:8];
                default: tx_byte = FLASH_OFFSET[7:0];
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_CMD;
            ST_CMD:
                if (byte_valid && byte_cnt == 3'(CMD_BYTES - 1)) state_next = ST_HDR;
            ST_HDR:
                if (byte_valid && byte_cnt == 3'(HDR_BYTES - 1)) begin
                    if (magic_r != MAGIC)    state_next = ST_ERR;
                    else if (len_r == 16'd0) state_next = ST_CSUM;
                    else                     state_next = ST_DATA;
                end
            ST_DATA:
                if (byte_valid && byte_cnt == 3'(WORD_BYTES - 1)) state_next = ST_AHB_ADDR;
            ST_AHB_ADDR:
                if (spi_hready) state_next = ST_AHB_DATA;
            ST_AHB_DATA:
                if (spi_hready) begin
                    if (spi_hresp)                            state_next = ST_ERR;
                    else if (word_cnt + 15'd1 == len_words)   state_next = ST_CSUM;
                    else                                      state_next = ST_DATA;
                end
            ST_CSUM:
                if (byte_valid && byte_cnt == 3'(CSUM_BYTES - 1))
                    state_next = (rx_word[15:0] == sum) ? ST_DONE : ST_ERR;
            ST_DONE: state_next = ST_DONE;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
            base_addr <= '0;
            haddr_r   <= '0;
            hwdata_r  <= '0;
            magic_r   <= '0;
            len_r     <= '0;
            sum       <= '0;
            word_cnt  <= '0;
        end else begin
            if (state_next != state) byte_cnt <= '0;
            else if (byte_valid)     byte_cnt <= byte_cnt + 3'd1;

            if (byte_valid) shift_reg <= rx_word;

            if (state == ST_IDLE) begin
                sum      <= '0;
                word_cnt <= '0;
            end
            if (state == ST_HDR && byte_valid) begin
                if (byte_cnt == 3'd3) begin
                    magic_r <= rx_word[31:16];
                    len_r   <= rx_word[15:0];
                end
                if (byte_cnt == 3'(HDR_BYTES - 1)) base_addr <= rx_word;
            end
            if (state == ST_DATA && byte_valid) sum <= sum + {8'h00, rx_byte};
            // Word index is 14 bits; the 32-bit add wraps naturally.
            if (state == ST_DATA && state_next == ST_AHB_ADDR)
                haddr_r <= base_addr + {16'h0000, word_cnt[13:0], 2'b00};
            if (state == ST_AHB_ADDR && spi_hready) hwdata_r <= shift_reg;
            if (state == ST_AHB_DATA && spi_hready && !spi_hresp) word_cnt <= word_cnt + 15'd1;
        end
    end

    assign ss            = eng_ss | terminal;
    assign spien         = !terminal;
    assign core_rst      = (state != ST_DONE);
    assign load_done     = (state == ST_DONE);
    assign load_err      = (state == ST_ERR);
    assign spi_htrans    = (state == ST_AHB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign spi_hwrite    = (state == ST_AHB_ADDR);
    assign spi_haddr     = haddr_r;
    assign spi_hwdata    = hwdata_r;
    assign spi_hsize     = HSIZE_WORD;
    assign spi_hburst    = HBURST_SINGLE;
    assign spi_hmastlock = 1'b0;
    assign spi_hprot     = HPROT_VAL;

endmodule

// File: tb/tb_spi_boot_loader_v2.sv
// Bench for spi_boot_loader_v2: flash model, AHB responder and write scoreboard, two clock dividers.
module tb_spi_boot_loader_v2;
    import spi_boot_loader_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    localparam logic [4:0] ST_OK  = 5'b10010; // {done, err, core_rst, ss, spien}
    localparam logic [4:0] ST_BAD = 5'b01110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  miso, spi_clk, mosi, ss, spien, core_rst, load_done, load_err;
    logic [1:0]  hwrite, hmastlock, hready, hresp;
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [2:0]  hsize [2];
    logic [2:0]  hburst [2];
    logic [3:0]  hprot [2];
    logic [1:0]  htrans [2];
    logic [31:0] hrdata = 32'h0;

    int checks = 0;
    int errors = 0;
    logic [7:0]  img [$];
    logic [31:0] words [2];
    wr_t         exp0 [$];
    wr_t         exp1 [$];
    int          wr_seen0, wr_seen1, wait_n;
    bit          err_first;
    int          bit_i [2];
    logic        sclk_q [2];
    logic [31:0] cmd_cap [2];

    initial forever #5 clk = ~clk;

    spi_boot_loader_v2 u_dut (
        .clk(clk), .reset(reset), .miso(miso[0]), .spi_clk(spi_clk[0]), .mosi(mosi[0]), .ss(ss[0]),
        .spien(spien[0]), .core_rst(core_rst[0]), .load_done(load_done[0]), .load_err(load_err[0]),
        .spi_haddr(haddr[0]), .spi_hwrite(hwrite[0]), .spi_hsize(hsize[0]), .spi_hburst(hburst[0]),
        .spi_hmastlock(hmastlock[0]), .spi_hprot(hprot[0]), .spi_htrans(htrans[0]), .spi_hwdata(hwdata[0]),
        .spi_hready(hready[0]), .spi_hresp(hresp[0]), .spi_hrdata(hrdata)
    );

    spi_boot_loader_v2 #(.CLK_DIV(1)) u_dut_fast (
        .clk(clk), .reset(reset), .miso(miso[1]), .spi_clk(spi_clk[1]), .mosi(mosi[1]), .ss(ss[1]),
        .spien(spien[1]), .core_rst(core_rst[1]), .load_done(load_done[1]), .load_err(load_err[1]),
        .spi_haddr(haddr[1]), .spi_hwrite(hwrite[1]), .spi_hsize(hsize[1]), .spi_hburst(hburst[1]),
        .spi_hmastlock(hmastlock[1]), .spi_hprot(hprot[1]), .spi_htrans(htrans[1]), .spi_hwdata(hwdata[1]),
        .spi_hready(hready[1]), .spi_hresp(hresp[1]), .spi_hrdata(hrdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] status(input int i);
        return {load_done[i], load_err[i], core_rst[i], ss[i], spien[i]};
    endfunction

    function automatic logic img_bit(input int k);
        if (k / 8 < img.size()) return img[k / 8][7 - (k % 8)];
        return 1'b0;
    endfunction

    // Flash model: captures the command on rising spi_clk, shifts the image out on falling spi_clk.
    initial begin
        for (int i = 0; i < 2; i++) begin
            bit_i[i] = 0; sclk_q[i] = 1'b0; miso[i] = 1'b0; cmd_cap[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ss[i]) begin
                    bit_i[i] = 0;
                    miso[i] = 1'b0;
                end else if (spi_clk[i] && !sclk_q[i]) begin
                    if (bit_i[i] < 32) cmd_cap[i] = {cmd_cap[i][30:0], mosi[i]};
                    bit_i[i]++;
                end else if (!spi_clk[i] && sclk_q[i] && bit_i[i] >= 32) begin
                    miso[i] = img_bit(bit_i[i] - 32);
                end
                sclk_q[i] = spi_clk[i];
            end
        end
    end

    // AHB responder and scoreboard for both instances; the fast one always has hready = 1.
    initial begin
        int          stall;
        bit          dphase, f_dphase;
        logic [31:0] cap_addr, f_addr;
        wr_t         cur;
        hready = 2'b11; hresp = 2'b00;
        stall = 0; dphase = 0; f_dphase = 0; cap_addr = '0; f_addr = '0;
        forever begin
            @(negedge clk);
            hresp[0] = 1'b0;
            if (reset) begin
                stall = 0; dphase = 0; f_dphase = 0; hready[0] = 1'b1;
            end else begin
                if (dphase) begin
                    if (stall < wait_n) begin
                        hready[0] = 1'b0; stall++;
                        if (exp0.size() > 0) check("hwdata_stable", hwdata[0], exp0[0].data);
                        check("sclk_frozen_data", spi_clk[0], 1'b0);
                    end else begin
                        hready[0] = 1'b1; stall = 0; dphase = 0; wr_seen0++;
                        if (exp0.size() > 0) begin
                            cur = exp0.pop_front();
                            check("ahb_addr", cap_addr, cur.addr);
                            check("ahb_data", hwdata[0], cur.data);
                        end
                        if (err_first && wr_seen0 == 1) hresp[0] = 1'b1;
                    end
                end else if (htrans[0] == HTRANS_NONSEQ) begin
                    check("hwrite", hwrite[0], 1'b1);
                    if (stall < wait_n) begin
                        hready[0] = 1'b0; stall++;
                        if (exp0.size() > 0) check("haddr_stable", haddr[0], exp0[0].addr);
                        check("sclk_frozen_addr", spi_clk[0], 1'b0);
                    end else begin
                        hready[0] = 1'b1; stall = 0; dphase = 1; cap_addr = haddr[0];
                    end
                end else begin
                    hready[0] = 1'b1;
                end

                if (f_dphase) begin
                    f_dphase = 0; wr_seen1++;
                    if (exp1.size() > 0) begin
                        cur = exp1.pop_front();
                        check("fast_ahb_addr", f_addr, cur.addr);
                        check("fast_ahb_data", hwdata[1], cur.data);
                    end
                end
                if (htrans[1] == HTRANS_NONSEQ) begin
                    f_dphase = 1; f_addr = haddr[1];
                end
            end
        end
    end

    task automatic build_image(input logic [15:0] magic, input logic [15:0] len, input int nw,
                               input logic [15:0] csum);
        img.delete();
        img.push_back(magic[15:8]); img.push_back(magic[7:0]);
        img.push_back(len[15:8]);   img.push_back(len[7:0]);
        img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h02); img.push_back(8'h00);
        for (int w = 0; w < nw; w++)
            for (int b = 3; b >= 0; b--) img.push_back(words[w][8*b +: 8]);
        img.push_back(csum[15:8]); img.push_back(csum[7:0]);
    endtask

    task automatic start_run(input int nw0, input int nw1);
        @(negedge clk);
        reset = 1'b1;
        exp0.delete(); exp1.delete();
        for (int i = 0; i < nw0; i++) exp0.push_back('{addr: 32'h200 + 32'(4 * i), data: words[i]});
        for (int i = 0; i < nw1; i++) exp1.push_back('{addr: 32'h200 + 32'(4 * i), data: words[i]});
        wr_seen0 = 0; wr_seen1 = 0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {status(0), spi_clk[0], mosi[0], htrans[0], hwrite[0]}, {5'b00111, 5'b00000});
        check("reset_ahb", {haddr[0], hwdata[0]}, 64'h0);
        reset = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!((load_done[0] | load_err[0]) && (load_done[1] | load_err[1])) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("finish_in_time", {load_done[0] | load_err[0], load_done[1] | load_err[1]}, 2'b11);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_end(input logic [4:0] r0, input int w0, input logic [4:0] r1, input int w1);
        check("status", status(0), r0);
        check("write_count", wr_seen0, w0);
        check("writes_pending", exp0.size(), 0);
        check("flash_cmd", cmd_cap[0], 32'h0300_0000);
        check("fast_status", status(1), r1);
        check("fast_write_count", wr_seen1, w1);
        check("fast_writes_pending", exp1.size(), 0);
        check("fast_flash_cmd", cmd_cap[1], 32'h0300_0000);
    endtask

    initial begin
        int n;
        words[0] = 32'h1122_3344;
        words[1] = 32'h5566_7788;
        wait_n = 0; err_first = 0; wr_seen0 = 0; wr_seen1 = 0;

        // Nominal load
        build_image(16'hB007, 16'd8, 2, 16'h0264);
        start_run(2, 2); wait_end(); check_end(ST_OK, 2, ST_OK, 2);

        // Bad magic
        build_image(16'hDEAD, 16'd8, 2, 16'h0264);
        start_run(0, 0); wait_end(); check_end(ST_BAD, 0, ST_BAD, 0);

        // Checksum mismatch
        build_image(16'hB007, 16'd8, 2, 16'h0000);
        start_run(2, 2); wait_end(); check_end(ST_BAD, 2, ST_BAD, 2);

        // Wait states on every address and data phase
        wait_n = 3;
        build_image(16'hB007, 16'd8, 2, 16'h0264);
        start_run(2, 2); wait_end(); check_end(ST_OK, 2, ST_OK, 2);
        wait_n = 0;

        // AHB error on the first data phase
        err_first = 1;
        start_run(1, 2); wait_end(); check_end(ST_BAD, 1, ST_OK, 2);
        err_first = 0;

        // Reset during the second data word, then a full reload
        start_run(2, 2);
        n = 0;
        while (wr_seen0 < 1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("first_write_seen", wr_seen0, 1);
        repeat (300) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_ctl", {status(0), spi_clk[0], mosi[0], htrans[0], hwrite[0]}, {5'b00111, 5'b00000});
        check("midreset_ahb", {haddr[0], hwdata[0]}, 64'h0);
        start_run(2, 2); wait_end(); check_end(ST_OK, 2, ST_OK, 2);

        // Zero-length image
        build_image(16'hB007, 16'd0, 0, 16'h0000);
        start_run(0, 0); wait_end(); check_end(ST_OK, 0, ST_OK, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
